interrupt_control_unit: RTL and testbench

INTERRUPT_CONTROL_UNIT -- requirements
Module: interrupt_control_unit

---
 rtl/interrupt_control_unit_pkg.sv | 24 ++
 rtl/interrupt_control_unit.sv | 130 +++++++++++++
 tb/tb_interrupt_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_control_unit_pkg.sv
// Shared processor encodings: ICU sequence states and the control-line codes
// the ICU drives in place of the control unit.
package interrupt_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PUSH_PC_HI = 3'd1,
        ST_PUSH_PC_LO = 3'd2,
        ST_PUSH_FLAGS = 3'd3,
        ST_LOAD_VEC   = 3'd4,
        ST_JUMP       = 3'd5
    } icu_state_e;

    localparam logic [1:0] PUSH_SRC_NONE  = 2'b00;
    localparam logic [1:0] PUSH_SRC_PC_HI = 2'b01;
    localparam logic [1:0] PUSH_SRC_PC_LO = 2'b10;
    localparam logic [1:0] PUSH_SRC_FLAGS = 2'b11;

    localparam logic [3:0] ALU_FN_PASS = 4'b0000;
    localparam logic [3:0] ALU_FN_SP   = 4'b0100;

    localparam logic [1:0] BR_ALWAYS = 2'b11;

endpackage

// File: rtl/interrupt_control_unit.sv
// Interrupt control unit: on an int_req rising edge, pushes PC and flags,
// fetches the ISR address from VEC_ADDR and jumps there, owning the control lines.
module interrupt_control_unit
    import interrupt_control_unit_pkg::*;
#(
    parameter int ALU_W    = 4,
    parameter int VEC_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_req,
    input  logic             stall,
    input  logic             rti_done,
    output logic             int_flag,
    output logic [ALU_W-1:0] alu_function,
    output logic             branch,
    output logic [1:0]       branch_type,
    output logic             data_read,
    output logic             data_write,
    output logic             DMR,
    output logic             DMW,
    output logic             stack_operation,
    output logic             push_pop,
    output logic             write_sp,
    output logic [1:0]       push_src,
    output logic             vec_sel,
    output logic             pc_from_mem,
    output logic             in_isr
);

    // The ALU codes are 4 bits wide; a narrower bus would corrupt them.
    if (ALU_W < 4 || VEC_ADDR < 0) begin : g_bad_cfg
        $error("interrupt_control_unit: ALU_W must be >= 4 and VEC_ADDR >= 0");
    end

    icu_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic       in_isr_q, in_isr_d;
    logic       int_req_q, int_req_d;
    logic       armed_q, armed_d;
    logic       req_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            in_isr_q  <= 1'b0;
            int_req_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            in_isr_q  <= in_isr_d;
            int_req_q <= int_req_d;
            armed_q   <= armed_d;
        end
    end

    // armed_q masks the first sampled cycle after reset, so a level already
    // high at release is absorbed into the history instead of seen as an edge.
    always_comb begin
        req_edge  = armed_q & int_req & ~int_req_q;
        state_d   = state_q;
        pending_d = pending_q | req_edge;
        in_isr_d  = in_isr_q & ~rti_done;
        int_req_d = int_req;
        armed_d   = 1'b1;
        if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if ((pending_q | req_edge) && !in_isr_q) begin
                        state_d   = ST_PUSH_PC_HI;
                        pending_d = 1'b0;
                    end
                end
                ST_PUSH_PC_HI: state_d = ST_PUSH_PC_LO;
                ST_PUSH_PC_LO: state_d = ST_PUSH_FLAGS;
                ST_PUSH_FLAGS: state_d = ST_LOAD_VEC;
                ST_LOAD_VEC:   state_d = ST_JUMP;
                ST_JUMP: begin
                    state_d  = ST_IDLE;
                    in_isr_d = 1'b1;
                end
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        int_flag        = (state_q != ST_IDLE);
        alu_function    = ALU_W'(ALU_FN_PASS);
        branch          = 1'b0;
        branch_type     = 2'b00;
        data_read       = 1'b0;
        data_write      = 1'b0;
        DMR             = 1'b0;
        DMW             = 1'b0;
        stack_operation = 1'b0;
        push_pop        = 1'b0;
        write_sp        = 1'b0;
        push_src        = PUSH_SRC_NONE;
        vec_sel         = 1'b0;
        pc_from_mem     = 1'b0;
        in_isr          = in_isr_q;
        unique case (state_q)
            ST_PUSH_PC_HI, ST_PUSH_PC_LO, ST_PUSH_FLAGS: begin
                alu_function    = ALU_W'(ALU_FN_SP);
                stack_operation = 1'b1;
                push_pop        = 1'b1;
                DMW             = 1'b1;
                write_sp        = 1'b1;
                push_src        = (state_q == ST_PUSH_PC_HI) ? PUSH_SRC_PC_HI :
                                  (state_q == ST_PUSH_PC_LO) ? PUSH_SRC_PC_LO : PUSH_SRC_FLAGS;
            end
            ST_LOAD_VEC: begin
                alu_function = ALU_W'(ALU_FN_PASS);
                DMR          = 1'b1;
                vec_sel      = 1'b1;
            end
            ST_JUMP: begin
                alu_function = ALU_W'(ALU_FN_SP);
                branch       = 1'b1;
                branch_type  = BR_ALWAYS;
                pc_from_mem  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Self-checking bench for interrupt_control_unit: directed scenarios plus
// randomized traffic against a step-counter reference model.
module tb_interrupt_control_unit;

    logic       clk, rst, int_req, stall, rti_done;
    logic       int_flag, branch, data_read, data_write, DMR, DMW;
    logic       stack_operation, push_pop, write_sp, vec_sel, pc_from_mem, in_isr;
    logic [3:0] alu_function;
    logic [1:0] branch_type, push_src;
    logic [19:0] obs;

    int total, passed, cyc;

    // Reference model: m_step counts sequence cycles, 0 = idle, 1..5 = active.
    int   m_step;
    logic m_pend, m_isr, m_prev, m_armed;

    interrupt_control_unit #(.ALU_W(4), .VEC_ADDR(0)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .stall(stall), .rti_done(rti_done),
        .int_flag(int_flag), .alu_function(alu_function), .branch(branch),
        .branch_type(branch_type), .data_read(data_read), .data_write(data_write),
        .DMR(DMR), .DMW(DMW), .stack_operation(stack_operation), .push_pop(push_pop),
        .write_sp(write_sp), .push_src(push_src), .vec_sel(vec_sel),
        .pc_from_mem(pc_from_mem), .in_isr(in_isr)
    );

    assign obs = {int_flag, alu_function, branch, branch_type, data_read, data_write,
                  DMR, DMW, stack_operation, push_pop, write_sp, push_src, vec_sel,
                  pc_from_mem, in_isr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] exp_vec();
        logic flag, br, dmr, dmw, so, pp, wsp, vs, pfm;
        logic [3:0] alu;
        logic [1:0] bt, ps;
        flag = (m_step != 0);
        alu = 4'b0000; br = 0; bt = 2'b00; dmr = 0; dmw = 0; so = 0; pp = 0;
        wsp = 0; ps = 2'b00; vs = 0; pfm = 0;
        if (m_step >= 1 && m_step <= 3) begin
            alu = 4'b0100; so = 1; pp = 1; dmw = 1; wsp = 1; ps = 2'(m_step);
        end else if (m_step == 4) begin
            dmr = 1; vs = 1;
        end else if (m_step == 5) begin
            br = 1; bt = 2'b11; pfm = 1; alu = 4'b0100;
        end
        return {flag, alu, br, bt, 1'b0, 1'b0, dmr, dmw, so, pp, wsp, ps, vs, pfm, m_isr};
    endfunction

    task automatic model_reset();
        m_step = 0; m_pend = 0; m_isr = 0; m_prev = 0; m_armed = 0;
    endtask

    task automatic model_update(input logic req, input logic stl, input logic rti);
        logic edge_seen, clr;
        edge_seen = m_armed && req && !m_prev;
        m_prev    = req;
        m_armed   = 1'b1;
        clr       = rti;
        m_pend    = m_pend || edge_seen;
        if (!stl) begin
            if (m_step == 0) begin
                if (m_pend && !m_isr) begin
                    m_step = 1;
                    m_pend = 1'b0;
                end
            end else if (m_step == 5) begin
                m_step = 0;
                m_isr  = 1'b1;
                clr    = 1'b0;
            end else begin
                m_step = m_step + 1;
            end
        end
        if (clr) m_isr = 1'b0;
    endtask

    // Entered and left at a negedge; inputs apply to the cycle ending at the next posedge.
    task automatic step_cycle(input logic req, input logic stl, input logic rti);
        int_req = req; stall = stl; rti_done = rti;
        @(posedge clk);
        model_update(req, stl, rti);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic req_level);
        rst = 1'b1; int_req = req_level; stall = 1'b0; rti_done = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs !== 20'h0) $display("FAIL reset_outputs got %h want %h", obs, 20'h0);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        // int_req already high at release must not start a sequence.
        for (int k = 0; k < 8; k++) begin
            step_cycle(1'b1, 1'b0, 1'b0);
            total++;
            if (int_flag !== 1'b0 || obs !== exp_vec())
                $display("FAIL reset_high_release cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_single_pulse();
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) begin
            step_cycle(k == 10, 1'b0, 1'b0);
            total++;
            if (int_flag !== (cyc >= 11 && cyc <= 15))
                $display("FAIL pulse_flag cyc=%0d got %b want %b", cyc, int_flag, (cyc >= 11 && cyc <= 15));
            else passed++;
            total++;
            if (in_isr !== (cyc >= 16))
                $display("FAIL pulse_in_isr cyc=%0d got %b want %b", cyc, in_isr, (cyc >= 16));
            else passed++;
            if (cyc >= 11 && cyc <= 13) begin
                total++;
                if (push_src !== 2'(cyc - 10))
                    $display("FAIL pulse_push_src cyc=%0d got %b want %b", cyc, push_src, 2'(cyc - 10));
                else passed++;
            end
            if (cyc == 14) begin
                total++;
                if ({DMR, vec_sel} !== 2'b11)
                    $display("FAIL pulse_load_vec got %b want 11", {DMR, vec_sel});
                else passed++;
            end
            if (cyc == 15) begin
                total++;
                if ({branch, branch_type, pc_from_mem} !== 4'b1111)
                    $display("FAIL pulse_jump got %b want 1111", {branch, branch_type, pc_from_mem});
                else passed++;
            end
            total++;
            if (obs !== exp_vec())
                $display("FAIL pulse_model cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_stall();
        int flag_cnt, lo_cnt;
        flag_cnt = 0; lo_cnt = 0;
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) begin
            step_cycle(k == 2, (k >= 4 && k <= 6), 1'b0);
            if (int_flag === 1'b1) flag_cnt++;
            if (push_src === 2'b10) lo_cnt++;
            total++;
            if (obs !== exp_vec())
                $display("FAIL stall_model cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
        total++;
        if (lo_cnt != 4) $display("FAIL stall_push_lo_cycles got %0d want 4", lo_cnt);
        else passed++;
        total++;
        if (flag_cnt != 8) $display("FAIL stall_active_cycles got %0d want 8", flag_cnt);
        else passed++;
    endtask

    task automatic test_masking();
        do_reset(1'b0);
        for (int k = 0; k < 25; k++) begin
            step_cycle(k == 1 || k == 9, 1'b0, k == 15);
            if (cyc >= 8 && cyc <= 16) begin
                total++;
                if (int_flag !== 1'b0) $display("FAIL mask_no_start cyc=%0d got %b want 0", cyc, int_flag);
                else passed++;
            end
            if (cyc == 16) begin
                total++;
                if (in_isr !== 1'b0) $display("FAIL mask_isr_clear got %b want 0", in_isr);
                else passed++;
            end
            if (cyc == 17) begin
                total++;
                if (int_flag !== 1'b1) $display("FAIL mask_late_start got %b want 1", int_flag);
                else passed++;
            end
            total++;
            if (obs !== exp_vec())
                $display("FAIL mask_model cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        // Second edge at k=3 leaves pending set when reset hits.
        for (int k = 0; k < 4; k++) step_cycle(k == 1 || k == 3, 1'b0, 1'b0);
        total++;
        if (push_src !== 2'b11) $display("FAIL rstmid_in_flags got %b want 11", push_src);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== 20'h0) $display("FAIL rstmid_async_zero got %h want %h", obs, 20'h0);
        else passed++;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            step_cycle(1'b0, 1'b0, 1'b0);
            total++;
            if (int_flag !== 1'b0 || obs !== exp_vec())
                $display("FAIL rstmid_no_resume cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_held_level();
        int starts;
        logic prev_flag;
        starts = 0; prev_flag = 1'b0;
        do_reset(1'b0);
        for (int k = 0; k < 40; k++) begin
            step_cycle(k >= 2 && k < 22, 1'b0, k == 12);
            if (int_flag === 1'b1 && prev_flag === 1'b0) starts++;
            prev_flag = int_flag;
            total++;
            if (obs !== exp_vec())
                $display("FAIL held_model cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
        total++;
        if (starts != 1) $display("FAIL held_sequences got %0d want 1", starts);
        else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0);
        for (int k = 0; k < 21; k++) begin
            step_cycle(k == 1 || k == 10, 1'b0, k == 10);
            if (cyc == 11) begin
                total++;
                if ({in_isr, int_flag} !== 2'b00)
                    $display("FAIL simul_clear got %b want 00", {in_isr, int_flag});
                else passed++;
            end
            if (cyc == 12) begin
                total++;
                if ({int_flag, push_src} !== 3'b101)
                    $display("FAIL simul_start got %b want 101", {int_flag, push_src});
                else passed++;
            end
            total++;
            if (obs !== exp_vec())
                $display("FAIL simul_model cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_random();
        logic req, stl, rti;
        req = 1'b0;
        do_reset(1'b0);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) req = ~req;
            stl = ($urandom_range(4) == 0);
            rti = (m_isr && m_step == 0 && $urandom_range(7) == 0);
            step_cycle(req, stl, rti);
            total++;
            if (obs !== exp_vec())
                $display("FAIL random_model cyc=%0d got %h want %h", cyc, obs, exp_vec());
            else passed++;
        end
    endtask

    initial begin
        total = 0; passed = 0; cyc = 0;
        rst = 1'b1; int_req = 1'b0; stall = 1'b0; rti_done = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_pulse();
        test_stall();
        test_masking();
        test_reset_mid();
        test_held_level();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
